// File: rtl/out_writeback_if.sv
// Row-input and BRAM-write handshake bundle for out_writeback.
// The slave modport is the write-back unit; master is the upstream stage plus BRAM side.
interface out_writeback_if #(
   parameter int MAT_MUL_SIZE = 4,
   parameter int DWIDTH       = 8,
   parameter int AWIDTH       = 10
);
   logic                             in_data_available;
   logic [MAT_MUL_SIZE*DWIDTH-1:0]   inp_data;
   logic [MAT_MUL_SIZE-1:0]          validity_mask;
   logic                             in_ready;
   logic                             bram_grant;
   logic [AWIDTH-1:0]                bram_addr;
   logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_wdata;
   logic [MAT_MUL_SIZE-1:0]          bram_we;

   modport master (
      output in_data_available, inp_data, validity_mask, bram_grant,
      input  in_ready, bram_addr, bram_wdata, bram_we
   );

   modport slave (
      input  in_data_available, inp_data, validity_mask, bram_grant,
      output in_ready, bram_addr, bram_wdata, bram_we
   );
endinterface

// File: rtl/out_writeback.sv
// FIFO-buffered write-back of result rows into BRAM port 0 with base/stride addressing.
// Optional OUT_WB_ELEMENT_MASK_EN: per-element write enables taken from the stored validity mask.
module out_writeback #(
   parameter int MAT_MUL_SIZE = 4,
   parameter int DWIDTH       = 8,
   parameter int AWIDTH       = 10,
   parameter int DEPTH        = 4,
   parameter int ROWW         = 8
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH-1:0] addr_stride,
   input  logic [ROWW-1:0]   num_rows,
   out_writeback_if.slave    bus,
   output logic              wb_active,
   output logic              done,
   output logic              overflow
);
   localparam int RW = MAT_MUL_SIZE * DWIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state_q;
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           count_q;
   logic [ROWW-1:0]         num_rows_q, pushed_q, rows_issued_q;
   logic [AWIDTH-1:0]       wr_addr_q, stride_q;
   logic [AWIDTH-1:0]       bram_addr_q;
   logic [RW-1:0]           bram_wdata_q;
   logic [MAT_MUL_SIZE-1:0] bram_we_q;
   logic                    wb_active_q, done_q, overflow_q;

   logic [RW-1:0]           data_mem [DEPTH];
   logic [RW-1:0]           head_data;
   logic [MAT_MUL_SIZE-1:0] head_we;
   logic                    in_ready, push, drop, pop, last_pop;

   // in_ready deliberately ignores a same-cycle pop so it depends only on registered state
   assign in_ready = (state_q == S_RUN) && (count_q < CW'(DEPTH));
   assign push     = in_ready && bus.in_data_available && (pushed_q < num_rows_q);
   assign drop     = (state_q == S_RUN) && bus.in_data_available && !push;
   assign pop      = (state_q == S_RUN) && (count_q != '0) && bus.bram_grant;
   assign last_pop = pop && ((rows_issued_q + ROWW'(1)) == num_rows_q);

   always_ff @(posedge clk) begin
      if (push) data_mem[wr_ptr_q] <= bus.inp_data;
   end

`ifdef OUT_WB_ELEMENT_MASK_EN
   logic [MAT_MUL_SIZE-1:0] mask_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (push) mask_mem[wr_ptr_q] <= bus.validity_mask;
   end

   // Masked lanes are zeroed so stale data never appears on the write bus
   always_comb begin
      head_we   = mask_mem[rd_ptr_q];
      head_data = data_mem[rd_ptr_q];
      for (int e = 0; e < MAT_MUL_SIZE; e++) begin
         if (!head_we[e]) head_data[e*DWIDTH +: DWIDTH] = '0;
      end
   end
`else
   logic unused_mask;
   assign unused_mask = ^bus.validity_mask;

   always_comb begin
      head_we   = '1;
      head_data = data_mem[rd_ptr_q];
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         num_rows_q    <= '0;
         pushed_q      <= '0;
         rows_issued_q <= '0;
         wr_addr_q     <= '0;
         stride_q      <= '0;
         bram_addr_q   <= '0;
         bram_wdata_q  <= '0;
         bram_we_q     <= '0;
         wb_active_q   <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         bram_we_q <= '0;
         done_q    <= 1'b0;
         if (drop) overflow_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_rows_q    <= num_rows;
                  stride_q      <= addr_stride;
                  wr_addr_q     <= base_addr;
                  rows_issued_q <= '0;
                  pushed_q      <= '0;
                  wr_ptr_q      <= '0;
                  rd_ptr_q      <= '0;
                  count_q       <= '0;
                  wb_active_q   <= 1'b1;
                  if (num_rows == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (push) begin
                  wr_ptr_q <= wr_ptr_q + PW'(1);
                  pushed_q <= pushed_q + ROWW'(1);
               end
               if (pop) begin
                  rd_ptr_q      <= rd_ptr_q + PW'(1);
                  bram_addr_q   <= wr_addr_q;
                  bram_wdata_q  <= head_data;
                  bram_we_q     <= head_we;
                  wr_addr_q     <= wr_addr_q + stride_q;
                  rows_issued_q <= rows_issued_q + ROWW'(1);
               end
               if (last_pop) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
               count_q <= count_q + CW'(push) - CW'(pop);
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               wb_active_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.bram_addr  = bram_addr_q;
   assign bus.bram_wdata = bram_wdata_q;
   assign bus.bram_we    = bram_we_q;
   assign wb_active      = wb_active_q;
   assign done           = done_q;
   assign overflow       = overflow_q;
endmodule

// File: tb/tb_out_writeback.sv
// Scoreboard testbench for out_writeback: expected writes queued at push, compared at bram_we.
// Honours OUT_WB_ELEMENT_MASK_EN when computing expected write enables and lane data.
module tb_out_writeback;
   localparam int MMS   = 4;
   localparam int DW    = 8;
   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam int ROWW  = 8;

   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [MMS*DW-1:0] data;
      logic [MMS-1:0]    we;
   } exp_t;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [AW-1:0]   addr_stride = '0;
   logic [ROWW-1:0] num_rows = '0;
   logic            wb_active, done, overflow;

   out_writeback_if #(.MAT_MUL_SIZE(MMS), .DWIDTH(DW), .AWIDTH(AW)) bus ();

   out_writeback #(
      .MAT_MUL_SIZE(MMS), .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .ROWW(ROWW)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .base_addr(base_addr), .addr_stride(addr_stride), .num_rows(num_rows),
      .bus(bus),
      .wb_active(wb_active), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int            checkCount = 0;
   int            errorCount = 0;
   int            cyc = 0;
   exp_t          sbQ[$];
   logic [AW-1:0] baseM, strideM;
   int            idxM;
   int            writeCount, doneCount, firstWriteCycle, lastWriteCycle;
   logic [AW-1:0] lastDoneAddr;
   logic [MMS-1:0] lastDoneWe;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [MMS*DW-1:0] laneMask(input logic [MMS*DW-1:0] d, input logic [MMS-1:0] m);
      logic [MMS*DW-1:0] r;
      r = d;
      for (int e = 0; e < MMS; e++) if (!m[e]) r[e*DW +: DW] = '0;
      return r;
   endfunction

   // Scoreboard consumer: every asserted bram_we must match the oldest expected row
   always @(negedge clk) begin
      exp_t e;
      if (bus.bram_we != '0) begin
         writeCount++;
         if (writeCount == 1) firstWriteCycle = cyc;
         lastWriteCycle = cyc;
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_write", 64'(bus.bram_we), 64'h0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("wr_addr", 64'(bus.bram_addr), 64'(e.addr));
            checkOutput("wr_data", 64'(bus.bram_wdata), 64'(e.data));
            checkOutput("wr_we", 64'(bus.bram_we), 64'(e.we));
         end
      end
      if (done) begin
         doneCount++;
         lastDoneAddr = bus.bram_addr;
         lastDoneWe   = bus.bram_we;
      end
   end

   task automatic clearStats();
      writeCount = 0;
      doneCount  = 0;
      firstWriteCycle = 0;
      lastWriteCycle  = 0;
      lastDoneAddr = '0;
      lastDoneWe   = '0;
   endtask

   task automatic applyReset();
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      sbQ.delete();
   endtask

   task automatic startRun(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [ROWW-1:0] n);
      start = 1'b1;
      base_addr = b;
      addr_stride = s;
      num_rows = n;
      baseM = b;
      strideM = s;
      idxM = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offers one row for one cycle; accepted rows become expected BRAM writes
   task automatic applyStimulus(input logic [MMS*DW-1:0] d, input logic [MMS-1:0] m, input logic expAccept);
      exp_t e;
      bus.in_data_available = 1'b1;
      bus.inp_data = d;
      bus.validity_mask = m;
      checkOutput("in_ready", 64'(bus.in_ready), 64'(expAccept));
      if (expAccept) begin
         e.addr = baseM + AW'(idxM) * strideM;
`ifdef OUT_WB_ELEMENT_MASK_EN
         e.we   = m;
         e.data = laneMask(d, m);
`else
         e.we   = '1;
         e.data = d;
`endif
         sbQ.push_back(e);
         idxM++;
      end
      @(posedge clk); #1;
      bus.in_data_available = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sb_drained", 64'(sbQ.size()), 64'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      logic [MMS-1:0] expWe;
      bus.in_data_available = 1'b0;
      bus.inp_data = '0;
      bus.validity_mask = '0;
      bus.bram_grant = 1'b0;
      clearStats();
      #2;
      checkOutput("rst_bram_we", 64'(bus.bram_we), 64'h0);
      checkOutput("rst_bram_addr", 64'(bus.bram_addr), 64'h0);
      checkOutput("rst_bram_wdata", 64'(bus.bram_wdata), 64'h0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'h0);
      checkOutput("rst_wb_active", 64'(wb_active), 64'h0);
      checkOutput("rst_done", 64'(done), 64'h0);
      checkOutput("rst_overflow", 64'(overflow), 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;

      $display("[TB] basic run");
      bus.bram_grant = 1'b1;
      clearStats();
      startRun(10'h040, 10'd4, 8'd4);
      checkOutput("basic_wb_active", 64'(wb_active), 64'h1);
      t0 = cyc;
      for (int i = 0; i < 4; i++) applyStimulus(32'h11223344 + i * 32'h01010101, 4'hF, 1'b1);
      waitDrain(20);
      checkOutput("basic_writes", 64'(writeCount), 64'd4);
      checkOutput("basic_latency", 64'(firstWriteCycle), 64'(t0 + 2));
      checkOutput("basic_b2b", 64'(lastWriteCycle - firstWriteCycle), 64'd3);
      checkOutput("basic_done_count", 64'(doneCount), 64'd1);
      checkOutput("basic_done_addr", 64'(lastDoneAddr), 64'h04C);
      checkOutput("basic_done_we", 64'(lastDoneWe), 64'hF);
      checkOutput("basic_overflow", 64'(overflow), 64'h0);
      checkOutput("basic_wb_idle", 64'(wb_active), 64'h0);

      $display("[TB] grant stall and full");
      applyReset();
      bus.bram_grant = 1'b0;
      clearStats();
      startRun(10'h100, 10'd4, 8'd6);
      for (int i = 0; i < 6; i++) begin
         if (i == 4) checkOutput("stall_ovf_before", 64'(overflow), 64'h0);
         applyStimulus(32'hA0000000 | 32'(i), 4'hF, (i < 4));
      end
      checkOutput("stall_overflow", 64'(overflow), 64'h1);
      checkOutput("stall_no_write", 64'(writeCount), 64'h0);
      bus.bram_grant = 1'b1;
      waitDrain(20);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_writes", 64'(writeCount), 64'd4);
      checkOutput("stall_no_done", 64'(doneCount), 64'd0);
      checkOutput("stall_wb_active", 64'(wb_active), 64'h1);
      checkOutput("stall_ovf_sticky", 64'(overflow), 64'h1);

      $display("[TB] address wrap");
      applyReset();
      bus.bram_grant = 1'b1;
      clearStats();
      startRun(10'h3FC, 10'd4, 8'd2);
      applyStimulus(32'hDEADBEEF, 4'hF, 1'b1);
      applyStimulus(32'hCAFEF00D, 4'hF, 1'b1);
      waitDrain(20);
      checkOutput("wrap_writes", 64'(writeCount), 64'd2);
      checkOutput("wrap_done_count", 64'(doneCount), 64'd1);
      checkOutput("wrap_done_addr", 64'(lastDoneAddr), 64'h000);

      $display("[TB] zero rows");
      clearStats();
      startRun(10'h123, 10'd4, 8'd0);
      checkOutput("zero_done", 64'(done), 64'h1);
      checkOutput("zero_we", 64'(bus.bram_we), 64'h0);
      @(posedge clk); #1;
      checkOutput("zero_done_fall", 64'(done), 64'h0);
      checkOutput("zero_wb_idle", 64'(wb_active), 64'h0);
      checkOutput("zero_writes", 64'(writeCount), 64'd0);
      checkOutput("zero_done_count", 64'(doneCount), 64'd1);

      $display("[TB] validity mask");
      clearStats();
      startRun(10'h200, 10'd4, 8'd2);
      applyStimulus(32'hA1B2C3D4, 4'b0011, 1'b1);
      applyStimulus(32'h55667788, 4'b1100, 1'b1);
      waitDrain(20);
`ifdef OUT_WB_ELEMENT_MASK_EN
      expWe = 4'b1100;
`else
      expWe = 4'b1111;
`endif
      checkOutput("mask_done_we", 64'(lastDoneWe), 64'(expWe));
      checkOutput("mask_writes", 64'(writeCount), 64'd2);

      $display("[TB] async reset mid-run");
      applyReset();
      bus.bram_grant = 1'b0;
      clearStats();
      startRun(10'h080, 10'd4, 8'd4);
      for (int i = 0; i < 3; i++) applyStimulus(32'h5A5A0000 | 32'(i), 4'hF, 1'b1);
      bus.bram_grant = 1'b1;
      @(posedge clk); #1;
      bus.bram_grant = 1'b0;
      @(negedge clk); #2;
      checkOutput("ar_pre_we", 64'(bus.bram_we), 64'hF);
      checkOutput("ar_pre_addr", 64'(bus.bram_addr), 64'h080);
      resetn = 1'b0;
      #1;
      checkOutput("ar_bram_we", 64'(bus.bram_we), 64'h0);
      checkOutput("ar_bram_addr", 64'(bus.bram_addr), 64'h0);
      checkOutput("ar_bram_wdata", 64'(bus.bram_wdata), 64'h0);
      checkOutput("ar_wb_active", 64'(wb_active), 64'h0);
      checkOutput("ar_in_ready", 64'(bus.in_ready), 64'h0);
      sbQ.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      bus.bram_grant = 1'b1;
      clearStats();
      repeat (6) @(posedge clk);
      #1;
      checkOutput("ar_no_write", 64'(writeCount), 64'd0);
      checkOutput("ar_idle", 64'(wb_active), 64'h0);
      startRun(10'h0C0, 10'd4, 8'd1);
      applyStimulus(32'h0BADCAFE, 4'hF, 1'b1);
      waitDrain(20);
      checkOutput("ar_restart_done", 64'(doneCount), 64'd1);
      checkOutput("ar_restart_addr", 64'(lastDoneAddr), 64'h0C0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end
endmodule

// File: doc/out_writeback.md
# out_writeback

Parametrised output write-back unit between the last enabled post-processing stage (norm/pool/activation) and write port 0 of the activation BRAM (matrix_A). It replaces the single flop stage in the top level. Result rows are buffered in a FIFO, and BRAM writes stall while the port is granted to the matmul reader. Addresses are generated from a programmable base and stride, and a single `done` pulse is raised once a programmed number of rows has been committed.

## Interface
- `MAT_MUL_SIZE`, 4: elements per row.
- `DWIDTH`, 8: bits per element.
- `AWIDTH`, 10: BRAM address width.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `ROWW`, 8: width of the row-count field.

- `clk` in 1: single clock for all logic.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Latches `base_addr`, `addr_stride` and `num_rows`.
- `base_addr` in AWIDTH: address of the first row.
- `addr_stride` in AWIDTH: address increment per row (normally MAT_MUL_SIZE).
- `num_rows` in ROWW: number of rows to commit.
- `validity_mask` in MAT_MUL_SIZE: per-element valid bits.
- `in_data_available` in 1: `inp_data` is valid this cycle.
- `inp_data` in MAT_MUL_SIZE*DWIDTH: one result row.
- `in_ready` out 1: FIFO can accept a row.
- `bram_grant` in 1: BRAM port 0 is available for writing this cycle.
- `bram_addr` out AWIDTH: write address.
- `bram_wdata` out MAT_MUL_SIZE*DWIDTH: write data.
- `bram_we` out MAT_MUL_SIZE: per-element write enable.
- `wb_active` out 1: high while the unit is not IDLE; top level uses it to select the BRAM port mux.
- `done` out 1: one-cycle completion pulse.
- `overflow` out 1: sticky error flag.

## Operation
- **States:**
  - IDLE.
  - RUN.
  - DONE: one cycle, then back to IDLE.
- **IDLE:**
  - `start` → RUN. Latch the programmed fields; `wr_addr` = `base_addr`; `rows_issued` = 0.
  - If `num_rows` = 0 at `start`, go straight to DONE.
  - `in_ready` = 0. Input rows are ignored; `overflow` is not set.
- **RUN, input side:**
  - `in_ready` = (`count` < DEPTH). It is computed from the registered `count` only; a same-cycle pop is not credited.
  - Push when `in_data_available` && `in_ready`.
  - `in_data_available` && !`in_ready` → row dropped, `overflow` set. It stays set until reset.
  - Rows arriving after `num_rows` rows have been pushed are dropped and set `overflow`.
- **RUN, write side:**
  - Pop when `count` > 0 && `bram_grant`.
  - On a pop, the next edge registers `bram_addr` = `wr_addr`, `bram_wdata` = head row and `bram_we` = mask (see Configuration).
  - Then `wr_addr` += `addr_stride`, modulo 2^AWIDTH (wraps silently), and `rows_issued` += 1.
  - With no pop, `bram_we` = 0 next cycle and `bram_addr`/`bram_wdata` hold their values.
- **Simultaneous push and pop** in one cycle: `count` is unchanged, and FIFO order is preserved.
- **Completion:**
  - When the pop makes `rows_issued` = `num_rows`, go to DONE.
  - `done` = 1 for the single DONE cycle, coincident with the final `bram_we` cycle. Then IDLE.
- **`start` during RUN or DONE** is ignored; no re-latch.
- **`validity_mask`** is sampled with each pushed row and stored alongside it.

## Timing
- **Reset values:** state IDLE; `count`, `rows_issued` = 0; `bram_addr`, `bram_wdata`, `bram_we` = 0; `in_ready`, `wb_active`, `done`, `overflow` = 0.
- **Reset mid-operation:** the FIFO contents are discarded and no further writes are issued.
- **Latency:** a push at edge E0 with `bram_grant` = 1 in the following cycle gives `bram_we` high after edge E1. This is one cycle of latency.
- **Throughput:** one row per cycle sustained while `bram_grant` = 1.
- **`wb_active`** rises one cycle after `start` and falls one cycle after `done`.
- **Output timing:** all outputs are registered except `in_ready`, which is decoded from registered `count` and state.

## Configuration
- **`OUT_WB_ELEMENT_MASK_EN`**
  - **Defined:** `bram_we` = stored validity_mask of the row. Masked elements are not written, and their `bram_wdata` lanes are driven to 0.
  - **Undefined:** `bram_we` = all ones on every write. The mask is neither stored nor used, so no FIFO storage is spent on it.

## Test plan
- **Basic run:** `base_addr` = 0x040, `addr_stride` = 4, `num_rows` = 4, `bram_grant` held 1, four back-to-back rows pushed → writes to 0x040, 0x044, 0x048, 0x04C on consecutive cycles. `done` is high with the 0x04C write. `overflow` = 0.
- **Grant stall / full:** DEPTH = 4, `bram_grant` = 0 for 6 cycles, 6 rows offered → `in_ready` falls after 4 pushes and rows 5 and 6 are dropped with `overflow` = 1. After grant returns, exactly 4 writes occur in order, and no `done` is raised because `num_rows` = 6.
- **Wrap:** AWIDTH = 10, `base_addr` = 0x3FC, `addr_stride` = 4, `num_rows` = 2 → writes to 0x3FC, then 0x000.
- **Zero rows:** `start` with `num_rows` = 0 → `done` pulses 1 cycle later, with no `bram_we` asserted.
- **Mask:** with `OUT_WB_ELEMENT_MASK_EN` defined and `validity_mask` = 4'b0011 → `bram_we` = 4'b0011 and upper lanes = 0. Without the macro → `bram_we` = 4'b1111.
- **Async reset:** `resetn` low mid-RUN with 2 rows buffered → all outputs are 0 immediately. After release, `start` is required before any further writes occur.
